hash160_seq_ctrl: RTL and testbench
===================================

Name: hash160_seq_ctrl

Overview:
- Top-level sequencer for the Hash160 datapath.
- Collects a 64-byte message from the byte stream and runs the SHA-256 core for two blocks: the message block, then the padding block.
- Pads the 32-byte SHA digest into one RIPEMD-160 block and runs the RIPEMD-160 core.
- Streams the 160-bit result out as ten 16-bit words on consecutive cycles.

Parameters:
- MSG_BYTES, 64: bytes per message; only 64 is supported; the padding constants depend on it.
- TIMEOUT, 1023: maximum cycles to wait for a core done pulse before aborting.
- OUT_WORDS, 10: 16-bit output words per result.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- i_valid  in  1  i_text carries a message byte this cycle.
- i_text  in  8  message byte, byte 0 first.
- o_answer  out  16  result word.
- o_valid  out  1  o_answer valid.
- o_busy  out  1  high in every state except IDLE and LOAD.
- o_err  out  1  one-cycle pulse on core timeout.
- sha_start  out  1  one-cycle start pulse to the SHA-256 core.
- sha_init  out  1  1 = first block (load IV); 0 = chain from previous block; valid with sha_start.
- sha_block  out  512  block; byte 0 in [511:504].
- sha_done  in  1  one-cycle done pulse.
- sha_digest  in  256  digest; byte 0 in [255:248].
- rmd_start  out  1  one-cycle start pulse to the RIPEMD-160 core.
- rmd_block  out  512  block; byte 0 in [511:504].
- rmd_done  in  1  one-cycle done pulse.
- rmd_digest  in  160  digest; byte 0 in [159:152].

Behaviour:
- Reset values: all outputs 0; block buffer 0; byte counter 0; state IDLE.
- Reset takes effect immediately at any point, including mid-hash or mid-output. No start pulse is issued afterwards.
- IDLE:
  - i_valid=1 stores i_text as byte 0, sets count=1, goes to LOAD.
- LOAD:
  - Each cycle with i_valid=1 stores the byte at index count and increments count.
  - Gaps in i_valid are tolerated.
  - When byte 63 is accepted, go to SHA1 on the next edge.
- SHA1:
  - On entry: sha_start=1 and sha_init=1 for one cycle; sha_block = the 64 message bytes.
  - Wait for sha_done, then go to SHA2.
- SHA2:
  - Buffer is rewritten with the SHA padding block: byte0=0x80, bytes1..61=0x00, byte62=0x02, byte63=0x00 (bit length 512, big-endian).
  - sha_start pulse with sha_init=0.
  - Wait for sha_done, then go to RMD.
- RMD:
  - Buffer = sha_digest bytes 0..31, then byte32=0x80, bytes33..55=0x00, byte56=0x00, byte57=0x01, bytes58..63=0x00 (bit length 256, little-endian).
  - rmd_start pulse; wait for rmd_done.
  - Latch rmd_digest into the output register, go to OUT.
- OUT:
  - o_valid=1 for exactly 10 consecutive cycles, starting the cycle after rmd_done.
  - Word k = {digest byte 2k, byte 2k+1}, k=0..9.
  - After word 9: o_valid=0, state IDLE.
- Core handshake:
  - The block output is held stable from the start pulse until done.
  - A done pulse in the same cycle as its start pulse is ignored.
  - A done pulse from a core not being waited on is ignored.
- Timeout:
  - A wait counter resets on each start pulse.
  - If it reaches TIMEOUT without the expected done: o_err pulses for 1 cycle, state goes to IDLE, buffer is not cleared, o_valid stays 0.
- i_valid outside IDLE/LOAD is ignored; those bytes are dropped and not counted.
- i_valid in the same cycle as the OUT→IDLE transition is also ignored. It is accepted from IDLE on the following cycle.

Decomposition:
- Package hash160_pkg:
  - state enum {IDLE, LOAD, SHA1, SHA2, RMD, OUT};
  - SHA_PAD_BLOCK 512-bit constant;
  - RMD_PAD_TAIL 256-bit constant (bytes 32..63);
  - MSG_BYTES, OUT_WORDS.
- Sub-module hash160_out_ser: 160-bit load, 4-bit word counter, 16-bit word output and o_valid. Loaded by the controller on rmd_done.

Test Plan:
- Stub cores that pulse done 5 cycles after start. Stream bytes 0x00..0x3F → after byte 63: sha_start with sha_init=1, sha_block=0x000102…3F. Second sha_start has sha_init=0 and the block is 0x80, 61×0x00, 0x02, 0x00.
- Stub sha_digest=0x00..0x1F → rmd_block = 0x00..0x1F, 0x80, 23×0x00, 0x00, 0x01, 6×0x00.
- Stub rmd_digest=0x0123456789ABCDEF0011223344556677DEADBEEF → o_valid high 10 cycles with words 0123, 4567, 89AB, CDEF, 0011, 2233, 4455, 6677, DEAD, BEEF.
- i_valid toggled every other cycle during load → same blocks as continuous load. Bytes sent while o_busy=1 do not alter the next message.
- sha_done never asserted → o_err pulses at TIMEOUT, state returns to IDLE, o_valid stays 0. A following message completes normally.
- rst asserted at word 4 of OUT → o_valid=0 immediately. Next 64 bytes produce a full 10-word result.

Source files
------------

// File: rtl/hash160_pkg.sv
// Shared state encoding and padding constants for the Hash160 sequencer.
// Padding constants assume a 64-byte message and a 32-byte SHA digest.
package hash160_pkg;

    localparam int MSG_BYTES = 64;
    localparam int OUT_WORDS = 10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SHA1 = 3'd2,
        SHA2 = 3'd3,
        RMD  = 3'd4,
        OUT  = 3'd5
    } state_t;

    // SHA-256 second block: 0x80 marker, bit length 512 big-endian in the last 8 bytes.
    localparam logic [511:0] SHA_PAD_BLOCK = {8'h80, {61{8'h00}}, 8'h02, 8'h00};

    // RIPEMD-160 bytes 32..63: 0x80 marker, bit length 256 little-endian at byte 56.
    localparam logic [255:0] RMD_PAD_TAIL = {8'h80, {23{8'h00}}, 8'h00, 8'h01, {6{8'h00}}};

    function automatic logic [8:0] byte_lsb(input logic [5:0] idx);
        return 9'd504 - {idx, 3'b000};
    endfunction

endpackage

// File: rtl/hash160_seq_ctrl_if.sv
// Byte stream, result stream and SHA-256 / RIPEMD-160 core handshake bundle.
// The slave modport is the sequencer's view; master is the surrounding system.
interface hash160_seq_ctrl_if;

    logic         i_valid;
    logic [7:0]   i_text;
    logic [15:0]  o_answer;
    logic         o_valid;
    logic         o_busy;
    logic         o_err;
    logic         sha_start;
    logic         sha_init;
    logic [511:0] sha_block;
    logic         sha_done;
    logic [255:0] sha_digest;
    logic         rmd_start;
    logic [511:0] rmd_block;
    logic         rmd_done;
    logic [159:0] rmd_digest;

    modport slave (
        input  i_valid, i_text, sha_done, sha_digest, rmd_done, rmd_digest,
        output o_answer, o_valid, o_busy, o_err, sha_start, sha_init, sha_block,
               rmd_start, rmd_block
    );

    modport master (
        output i_valid, i_text, sha_done, sha_digest, rmd_done, rmd_digest,
        input  o_answer, o_valid, o_busy, o_err, sha_start, sha_init, sha_block,
               rmd_start, rmd_block
    );

endinterface

// File: rtl/hash160_out_ser.sv
// Result serializer: latches the 160-bit digest and emits it as OUT_WORDS
// consecutive 16-bit words, most significant word first.
module hash160_out_ser
    import hash160_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [159:0] digest,
    output logic [15:0]  word,
    output logic         valid,
    output logic         last
);

    localparam logic [3:0] LAST_WORD = 4'(OUT_WORDS - 1);

    logic [159:0] shift_r;
    logic [3:0]   cnt_r;
    logic         valid_r;

    // Shift register and word counter; zeros shift in so the output idles at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r <= 160'd0;
            cnt_r   <= 4'd0;
            valid_r <= 1'b0;
        end else if (load) begin
            shift_r <= digest;
            cnt_r   <= 4'd0;
            valid_r <= 1'b1;
        end else if (valid_r) begin
            shift_r <= {shift_r[143:0], 16'h0000};
            if (cnt_r == LAST_WORD) begin
                cnt_r   <= 4'd0;
                valid_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r + 4'd1;
            end
        end
    end

    assign word  = shift_r[159:144];
    assign valid = valid_r;
    assign last  = valid_r && (cnt_r == LAST_WORD);

endmodule

// File: rtl/hash160_seq_ctrl.sv
// Hash160 sequencer: gathers 64 message bytes, runs SHA-256 over two blocks,
// pads the digest into one RIPEMD-160 block and streams the 160-bit result.
module hash160_seq_ctrl
    import hash160_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    hash160_seq_ctrl_if.slave bus
);

    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
    localparam logic [5:0]        LAST_BYTE = 6'(MSG_BYTES - 1);

    state_t            state_r, state_n;
    logic [5:0]        count_r, count_n;
    logic [511:0]      buf_r, buf_n;
    logic [WAIT_W-1:0] wait_r, wait_n;
    logic              sha_start_r, sha_start_n;
    logic              sha_init_r, sha_init_n;
    logic              rmd_start_r, rmd_start_n;
    logic              err_r, err_n;
    logic              busy_r;
    logic              load_s, last_s, timeout_s;
    logic [8:0]        lsb_s;
    logic [15:0]       answer_s;
    logic              out_valid_s;

    // Next-state, buffer and handshake decode; a done seen while its own start is still high is ignored.
    always_comb begin
        state_n     = state_r;
        count_n     = count_r;
        buf_n       = buf_r;
        wait_n      = wait_r;
        sha_start_n = 1'b0;
        sha_init_n  = sha_init_r;
        rmd_start_n = 1'b0;
        err_n       = 1'b0;
        load_s      = 1'b0;
        lsb_s       = byte_lsb(count_r);
        timeout_s   = (wait_r == WAIT_MAX);
        case (state_r)
            IDLE: begin
                if (bus.i_valid) begin
                    buf_n[511:504] = bus.i_text;
                    count_n        = 6'd1;
                    state_n        = LOAD;
                end else begin
                    count_n = 6'd0;
                end
            end
            LOAD: begin
                if (bus.i_valid) begin
                    buf_n[lsb_s +: 8] = bus.i_text;
                    count_n           = count_r + 6'd1;
                    if (count_r == LAST_BYTE) begin
                        state_n     = SHA1;
                        sha_start_n = 1'b1;
                        sha_init_n  = 1'b1;
                        wait_n      = {WAIT_W{1'b0}};
                    end else begin
                        state_n = LOAD;
                    end
                end else begin
                    state_n = LOAD;
                end
            end
            SHA1: begin
                if (bus.sha_done && !sha_start_r) begin
                    buf_n       = SHA_PAD_BLOCK;
                    sha_start_n = 1'b1;
                    sha_init_n  = 1'b0;
                    wait_n      = {WAIT_W{1'b0}};
                    state_n     = SHA2;
                end else if (timeout_s) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    wait_n = wait_r + 1'b1;
                end
            end
            SHA2: begin
                if (bus.sha_done && !sha_start_r) begin
                    buf_n       = {bus.sha_digest, RMD_PAD_TAIL};
                    rmd_start_n = 1'b1;
                    wait_n      = {WAIT_W{1'b0}};
                    state_n     = RMD;
                end else if (timeout_s) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    wait_n = wait_r + 1'b1;
                end
            end
            RMD: begin
                if (bus.rmd_done && !rmd_start_r) begin
                    load_s  = 1'b1;
                    state_n = OUT;
                end else if (timeout_s) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    wait_n = wait_r + 1'b1;
                end
            end
            OUT: begin
                if (last_s) begin
                    state_n = IDLE;
                end else begin
                    state_n = OUT;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, buffer and registered output flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            count_r     <= 6'd0;
            buf_r       <= 512'd0;
            wait_r      <= {WAIT_W{1'b0}};
            sha_start_r <= 1'b0;
            sha_init_r  <= 1'b0;
            rmd_start_r <= 1'b0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            count_r     <= count_n;
            buf_r       <= buf_n;
            wait_r      <= wait_n;
            sha_start_r <= sha_start_n;
            sha_init_r  <= sha_init_n;
            rmd_start_r <= rmd_start_n;
            err_r       <= err_n;
            busy_r      <= (state_n != IDLE) && (state_n != LOAD);
        end
    end

    hash160_out_ser u_out_ser (
        .clk    (clk),
        .rst    (rst),
        .load   (load_s),
        .digest (bus.rmd_digest),
        .word   (answer_s),
        .valid  (out_valid_s),
        .last   (last_s)
    );

    assign bus.o_answer  = answer_s;
    assign bus.o_valid   = out_valid_s;
    assign bus.o_busy    = busy_r;
    assign bus.o_err     = err_r;
    assign bus.sha_start = sha_start_r;
    assign bus.sha_init  = sha_init_r;
    assign bus.sha_block = buf_r;
    assign bus.rmd_start = rmd_start_r;
    assign bus.rmd_block = buf_r;

endmodule

// File: tb/tb_hash160_seq_ctrl.sv
// Scoreboard bench for hash160_seq_ctrl: stub cores answer 5 cycles after start,
// expected blocks and result words come from a byte-level padding model.
module tb_hash160_seq_ctrl;

    localparam int TIMEOUT = 1023;

    logic clk;
    logic rst;

    hash160_seq_ctrl_if bus ();

    hash160_seq_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic         init;
        logic [511:0] blk;
    } sha_exp_t;

    sha_exp_t     sha_q[$];
    logic [511:0] rmd_q[$];
    logic [15:0]  word_q[$];
    int           err_exp, checks, failures, words_seen, cyc, start_cyc;
    int           sha_pend, rmd_pend;
    bit           sha_en, echo, spur, junk;
    bit           sha_wait, rmd_wait;
    logic [511:0] sha_cap, rmd_cap;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] put_byte(input logic [511:0] b, input int idx, input logic [7:0] v);
        logic [511:0] r;
        r = b;
        r[511 - 8*idx -: 8] = v;
        return r;
    endfunction

    function automatic logic [511:0] msg_block(input logic [7:0] m[64]);
        logic [511:0] b;
        b = '0;
        for (int i = 0; i < 64; i++) b = put_byte(b, i, m[i]);
        return b;
    endfunction

    // MD-style padding: marker byte then the bit length in the last 8 bytes.
    function automatic logic [511:0] sha_pad();
        logic [511:0] b;
        longint unsigned len;
        len = 64 * 8;
        b = put_byte('0, 0, 8'h80);
        for (int i = 0; i < 8; i++) b = put_byte(b, 56 + i, 8'((len >> (8 * (7 - i))) & 64'hFF));
        return b;
    endfunction

    function automatic logic [511:0] rmd_pad(input logic [255:0] d);
        logic [511:0] b;
        longint unsigned len;
        len = 32 * 8;
        b = {d, 256'd0};
        b = put_byte(b, 32, 8'h80);
        for (int i = 0; i < 8; i++) b = put_byte(b, 56 + i, 8'((len >> (8 * i)) & 64'hFF));
        return b;
    endfunction

    task automatic expect_msg(input logic [7:0] m[64], input logic [255:0] sd, input logic [159:0] rd,
                              input bit tmo);
        bus.sha_digest = sd;
        bus.rmd_digest = rd;
        sha_q.push_back({1'b1, msg_block(m)});
        if (tmo) begin
            err_exp++;
        end else begin
            sha_q.push_back({1'b0, sha_pad()});
            rmd_q.push_back(rmd_pad(sd));
            for (int k = 0; k < 10; k++) word_q.push_back(16'(rd >> (160 - 16 * (k + 1))));
        end
    endtask

    task automatic send_msg(input logic [7:0] m[64], input int gap);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            bus.i_valid = 1'b1;
            bus.i_text  = m[i];
            if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
                @(negedge clk);
                bus.i_valid = 1'b0;
                bus.i_text  = 8'($urandom);
            end
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    // Waits for the scoreboard to drain and the sequencer to go idle, optionally feeding junk bytes while busy.
    task automatic wait_idle(input string name);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
            if (junk && bus.o_busy) begin
                bus.i_valid = 1'($urandom_range(0, 1));
                bus.i_text  = 8'($urandom);
            end else begin
                bus.i_valid = 1'b0;
            end
            done = (sha_q.size() == 0) && (rmd_q.size() == 0) && (word_q.size() == 0) &&
                   (err_exp == 0) && !bus.o_busy && !bus.o_valid;
        end
        chk(name, 512'(done), 512'd1);
        if (!done) begin
            sha_q.delete();
            rmd_q.delete();
            word_q.delete();
            err_exp = 0;
        end
    endtask

    task automatic rand_msg(output logic [7:0] m[64], output logic [255:0] sd, output logic [159:0] rd);
        for (int i = 0; i < 64; i++) m[i] = 8'($urandom);
        sd = '0;
        for (int i = 0; i < 8; i++) sd = {sd[223:0], 32'($urandom)};
        rd = '0;
        for (int i = 0; i < 5; i++) rd = {rd[127:0], 32'($urandom)};
    endtask

    // Stub cores: done 5 cycles after start, with optional same-cycle and cross-core stray dones.
    initial begin
        bus.sha_done = 1'b0;
        bus.rmd_done = 1'b0;
        sha_pend = 0;
        rmd_pend = 0;
        forever begin
            @(negedge clk);
            bus.sha_done = 1'b0;
            bus.rmd_done = 1'b0;
            if (rst) begin
                sha_pend = 0;
                rmd_pend = 0;
            end else begin
                if (sha_pend > 0) begin
                    sha_pend--;
                    if (sha_pend == 0) bus.sha_done = sha_en;
                    if (spur && sha_pend == 2) bus.rmd_done = 1'b1;
                end
                if (rmd_pend > 0) begin
                    rmd_pend--;
                    if (rmd_pend == 0) bus.rmd_done = 1'b1;
                    if (spur && rmd_pend == 2) bus.sha_done = 1'b1;
                end
                if (bus.sha_start) begin
                    sha_pend = 5;
                    if (echo) bus.sha_done = 1'b1;
                end
                if (bus.rmd_start) begin
                    rmd_pend = 5;
                    if (echo) bus.rmd_done = 1'b1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a start, a word or an error.
    initial begin
        sha_exp_t e;
        int lat;
        sha_wait = 1'b0;
        rmd_wait = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sha_wait = 1'b0;
                rmd_wait = 1'b0;
            end else begin
                if (bus.sha_start) begin
                    chk("sha_start_pending", 512'(sha_q.size() > 0), 512'd1);
                    chk("sha_start_after_done", 512'(sha_wait), 512'd0);
                    if (sha_q.size() > 0) begin
                        e = sha_q.pop_front();
                        chk("sha_init", 512'(bus.sha_init), 512'(e.init));
                        chk("sha_block", bus.sha_block, e.blk);
                    end
                    chk("busy_at_sha_start", 512'(bus.o_busy), 512'd1);
                    sha_cap   = bus.sha_block;
                    sha_wait  = 1'b1;
                    start_cyc = cyc;
                end else if (bus.sha_done && sha_wait) begin
                    chk("sha_block_stable", bus.sha_block, sha_cap);
                    sha_wait = 1'b0;
                end
                if (bus.rmd_start) begin
                    chk("rmd_start_pending", 512'(rmd_q.size() > 0), 512'd1);
                    chk("rmd_start_after_done", 512'(rmd_wait), 512'd0);
                    if (rmd_q.size() > 0) chk("rmd_block", bus.rmd_block, rmd_q.pop_front());
                    rmd_cap  = bus.rmd_block;
                    rmd_wait = 1'b1;
                end else if (bus.rmd_done && rmd_wait) begin
                    chk("rmd_block_stable", bus.rmd_block, rmd_cap);
                    rmd_wait = 1'b0;
                end
                if (bus.o_valid) begin
                    chk("word_pending", 512'(word_q.size() > 0), 512'd1);
                    if (word_q.size() > 0) chk("word", 512'(bus.o_answer), 512'(word_q.pop_front()));
                    words_seen++;
                end
                if (bus.o_err) begin
                    chk("err_pending", 512'(err_exp > 0), 512'd1);
                    if (err_exp > 0) err_exp--;
                    lat = cyc - start_cyc;
                    chk("err_latency", 512'(lat >= TIMEOUT && lat <= TIMEOUT + 3), 512'd1);
                    chk("err_no_valid", 512'(bus.o_valid), 512'd0);
                    sha_wait = 1'b0;
                    rmd_wait = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [7:0]   m[64];
        logic [255:0] sd;
        logic [159:0] rd;
        int n;
        checks = 0;
        failures = 0;
        err_exp = 0;
        words_seen = 0;
        start_cyc = 0;
        sha_en = 1'b1;
        echo = 1'b0;
        spur = 1'b0;
        junk = 1'b0;
        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_text = 8'h00;
        bus.sha_digest = '0;
        bus.rmd_digest = '0;
        repeat (3) @(negedge clk);
        chk("rst_o_valid", 512'(bus.o_valid), 512'd0);
        chk("rst_o_answer", 512'(bus.o_answer), 512'd0);
        chk("rst_o_busy", 512'(bus.o_busy), 512'd0);
        chk("rst_o_err", 512'(bus.o_err), 512'd0);
        chk("rst_sha_start", 512'(bus.sha_start), 512'd0);
        chk("rst_sha_init", 512'(bus.sha_init), 512'd0);
        chk("rst_rmd_start", 512'(bus.rmd_start), 512'd0);
        chk("rst_block", bus.sha_block, 512'd0);
        rst = 1'b0;

        // Directed message and digests.
        for (int i = 0; i < 64; i++) m[i] = 8'(i);
        for (int i = 0; i < 32; i++) sd[255 - 8 * i -: 8] = 8'(i);
        rd = 160'h0123456789ABCDEF0011223344556677DEADBEEF;
        expect_msg(m, sd, rd, 1'b0);
        send_msg(m, 0);
        wait_idle("idle_directed");

        // Alternate-cycle load, junk while busy, stray and same-cycle dones.
        junk = 1'b1;
        echo = 1'b1;
        spur = 1'b1;
        rand_msg(m, sd, rd);
        expect_msg(m, sd, rd, 1'b0);
        send_msg(m, 1);
        wait_idle("idle_gapped");
        echo = 1'b0;
        spur = 1'b0;

        // SHA core never answers.
        sha_en = 1'b0;
        rand_msg(m, sd, rd);
        expect_msg(m, sd, rd, 1'b1);
        send_msg(m, 0);
        wait_idle("idle_timeout");
        sha_en = 1'b1;
        rand_msg(m, sd, rd);
        expect_msg(m, sd, rd, 1'b0);
        send_msg(m, 0);
        wait_idle("idle_after_timeout");

        // Reset while word 4 is on the output.
        junk = 1'b0;
        rand_msg(m, sd, rd);
        expect_msg(m, sd, rd, 1'b0);
        words_seen = 0;
        send_msg(m, 0);
        n = 0;
        while (words_seen < 4 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("reached_word4", 512'(words_seen), 512'd4);
        #1 rst = 1'b1;
        #1;
        chk("midout_rst_o_valid", 512'(bus.o_valid), 512'd0);
        chk("midout_rst_o_answer", 512'(bus.o_answer), 512'd0);
        chk("midout_rst_o_busy", 512'(bus.o_busy), 512'd0);
        sha_q.delete();
        rmd_q.delete();
        word_q.delete();
        err_exp = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_no_start", 512'(bus.sha_start | bus.rmd_start | bus.o_busy), 512'd0);
        rand_msg(m, sd, rd);
        expect_msg(m, sd, rd, 1'b0);
        send_msg(m, 0);
        wait_idle("idle_after_reset");

        // Randomly gapped loads with junk during processing.
        junk = 1'b1;
        for (int r = 0; r < 3; r++) begin
            rand_msg(m, sd, rd);
            expect_msg(m, sd, rd, 1'b0);
            send_msg(m, 2);
            wait_idle("idle_random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
